// File: rtl/tx_spdif_framer.sv
// S/PDIF subframe assembler: packs big-endian PCM bytes into IEC 60958
// subframes for NUM_LANES stereo lanes, with parity, C-bit block and preambles.
module tx_spdif_framer #(
  parameter int NUM_LANES  = 1,
  parameter int STOP_DELAY = 4
) (
  input  logic                         byte_clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   bit_depth_i,
  input  logic [2:0]                   sample_rate_i,
  input  logic [7:0]                   byte_i,
  input  logic                         byte_valid_i,
  output logic                         byte_ready_o,
  output logic [31:0]                  sf_data_o,
  output logic [1:0]                   sf_preamble_o,
  output logic [$clog2(NUM_LANES):0]   sf_lane_o,
  output logic                         sf_valid_o,
  input  logic                         sf_ready_i,
  output logic                         streaming_o,
  output logic                         underrun_o
);

  localparam int CW = $clog2(NUM_LANES) + 1;
  localparam logic [CW-1:0] CH_LAST = CW'(2 * NUM_LANES - 1);
  localparam logic [3:0] DELAY = 4'(STOP_DELAY);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, STOP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     depth_q, depth_d;
  logic [2:0]     rate_q, rate_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [CW-1:0]  ch_idx_q, ch_idx_d;
  logic [7:0]     frame_idx_q, frame_idx_d;
  logic [23:0]    audio_q, audio_d;
  logic [31:0]    sf_data_q, sf_data_d;
  logic [1:0]     pre_q, pre_d;
  logic [CW-1:0]  lane_q, lane_d;
  logic           stream_q, stream_d;
  logic           underrun_q, underrun_d;
  logic [3:0]     starve_q, starve_d;
  logic [3:0]     stop_cnt_q, stop_cnt_d;

  logic [23:0]    audio_nxt;
  logic [1:0]     last_idx;
  logic           cbit;
  logic           mid_frame;

  // fs[0] is block bit 24, fs[3] is block bit 27
  function automatic logic cs_bit(input logic [7:0] n,
                                  input logic [1:0] depth,
                                  input logic [2:0] rate);
    logic [3:0] fs;
    logic       res;
    case (rate)
      3'd0:    fs = 4'b0000;
      3'd1:    fs = 4'b0010;
      3'd2:    fs = 4'b1000;
      3'd3:    fs = 4'b1010;
      3'd4:    fs = 4'b1100;
      3'd5:    fs = 4'b1110;
      default: fs = 4'b0001;
    endcase
    case (n)
      8'd2:                      res = 1'b1;
      8'd24, 8'd25, 8'd26, 8'd27: res = fs[n[1:0]];
      8'd32:                     res = (depth != 2'd0);
      8'd33:                     res = 1'b1;
      8'd35:                     res = (depth != 2'd0);
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    audio_nxt = audio_q;
    case (byte_idx_q)
      2'd0:    audio_nxt = {byte_i, 16'h0000};
      2'd1:    audio_nxt[15:8] = byte_i;
      2'd2:    audio_nxt[7:0] = byte_i;
      default: audio_nxt = audio_q;
    endcase
  end

  assign last_idx  = (depth_q == 2'd0) ? 2'd1 :
                     (depth_q == 2'd1) ? 2'd2 : 2'd3;
  assign cbit      = cs_bit(frame_idx_q, depth_q, rate_q);
  assign mid_frame = (byte_idx_q != 2'd0) || (ch_idx_q != '0);

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    rate_d      = rate_q;
    byte_idx_d  = byte_idx_q;
    ch_idx_d    = ch_idx_q;
    frame_idx_d = frame_idx_q;
    audio_d     = audio_q;
    sf_data_d   = sf_data_q;
    pre_d       = pre_q;
    lane_d      = lane_q;
    stream_d    = stream_q;
    underrun_d  = 1'b0;
    starve_d    = starve_q;
    stop_cnt_d  = stop_cnt_q;
    unique case (state_q)
      IDLE: begin
        starve_d = 4'd0;
        if (byte_valid_i && bit_depth_i != 2'd3) begin
          depth_d    = bit_depth_i;
          rate_d     = sample_rate_i;
          stream_d   = 1'b1;
          byte_idx_d = 2'd0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (byte_valid_i) begin
          starve_d = 4'd0;
          audio_d  = audio_nxt;
          if (byte_idx_q == last_idx) begin
            byte_idx_d = 2'd0;
            state_d    = EMIT;
            sf_data_d  = {^{cbit, audio_nxt}, cbit, 2'b00,
                          audio_nxt, 4'h0};
            pre_d      = ch_idx_q[0] ? 2'd2 :
                         (frame_idx_q == 8'd0) ? 2'd0 : 2'd1;
            lane_d     = ch_idx_q >> 1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (mid_frame) begin
          starve_d = starve_q + 4'd1;
          // Partial frame is dropped so the next start is frame-aligned
          if (starve_q + 4'd1 == DELAY) begin
            state_d     = IDLE;
            underrun_d  = 1'b1;
            stream_d    = 1'b0;
            byte_idx_d  = 2'd0;
            ch_idx_d    = '0;
            frame_idx_d = 8'd0;
            starve_d    = 4'd0;
          end
        end
      end
      EMIT: begin
        if (sf_ready_i) begin
          if (ch_idx_q == CH_LAST) begin
            ch_idx_d    = '0;
            frame_idx_d = (frame_idx_q == 8'd191) ? 8'd0 :
                          frame_idx_q + 8'd1;
            if (!byte_valid_i) begin
              state_d    = STOP;
              stop_cnt_d = DELAY;
            end else begin
              state_d = FILL;
            end
          end else begin
            ch_idx_d = ch_idx_q + CW'(1);
            state_d  = FILL;
          end
        end
      end
      STOP: begin
        if (byte_valid_i) begin
          state_d = FILL;
        end else if (stop_cnt_q <= 4'd1) begin
          state_d     = IDLE;
          stream_d    = 1'b0;
          frame_idx_d = 8'd0;
          stop_cnt_d  = 4'd0;
        end else begin
          stop_cnt_d = stop_cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      depth_q     <= 2'd0;
      rate_q      <= 3'd0;
      byte_idx_q  <= 2'd0;
      ch_idx_q    <= '0;
      frame_idx_q <= 8'd0;
      audio_q     <= 24'd0;
      sf_data_q   <= 32'd0;
      pre_q       <= 2'd0;
      lane_q      <= '0;
      stream_q    <= 1'b0;
      underrun_q  <= 1'b0;
      starve_q    <= 4'd0;
      stop_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      rate_q      <= rate_d;
      byte_idx_q  <= byte_idx_d;
      ch_idx_q    <= ch_idx_d;
      frame_idx_q <= frame_idx_d;
      audio_q     <= audio_d;
      sf_data_q   <= sf_data_d;
      pre_q       <= pre_d;
      lane_q      <= lane_d;
      stream_q    <= stream_d;
      underrun_q  <= underrun_d;
      starve_q    <= starve_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  assign byte_ready_o  = (state_q == FILL);
  assign sf_valid_o    = (state_q == EMIT);
  assign sf_data_o     = sf_data_q;
  assign sf_preamble_o = pre_q;
  assign sf_lane_o     = lane_q;
  assign streaming_o   = stream_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_tx_spdif_framer.sv
// Directed bench for tx_spdif_framer: one- and two-lane instances share
// the byte stream; each scenario task checks its own expectations.
module tb_tx_spdif_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  depth = 2'd1;
  logic [2:0]  rate = 3'd1;
  logic [7:0]  bytev = 8'h00;
  logic        valid = 1'b0;
  logic        sf_rdy_a = 1'b1;
  logic        sf_rdy_b = 1'b1;

  logic        rdy_a, sfv_a, str_a, und_a;
  logic [31:0] data_a;
  logic [1:0]  pre_a;
  logic [0:0]  lane_a;
  logic        rdy_b, sfv_b, str_b, und_b;
  logic [31:0] data_b;
  logic [1:0]  pre_b;
  logic [1:0]  lane_b;

  int vecs = 0;
  int fails = 0;
  bit use_b = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  p;
    logic [1:0]  l;
  } sf_t;
  sf_t qa[$];
  sf_t qb[$];

  tx_spdif_framer #(.NUM_LANES(1), .STOP_DELAY(4)) dut_a (
    .byte_clk_i(clk), .reset_i(rst), .bit_depth_i(depth),
    .sample_rate_i(rate), .byte_i(bytev), .byte_valid_i(valid),
    .byte_ready_o(rdy_a), .sf_data_o(data_a), .sf_preamble_o(pre_a),
    .sf_lane_o(lane_a), .sf_valid_o(sfv_a), .sf_ready_i(sf_rdy_a),
    .streaming_o(str_a), .underrun_o(und_a)
  );

  tx_spdif_framer #(.NUM_LANES(2), .STOP_DELAY(4)) dut_b (
    .byte_clk_i(clk), .reset_i(rst), .bit_depth_i(depth),
    .sample_rate_i(rate), .byte_i(bytev), .byte_valid_i(valid),
    .byte_ready_o(rdy_b), .sf_data_o(data_b), .sf_preamble_o(pre_b),
    .sf_lane_o(lane_b), .sf_valid_o(sfv_b), .sf_ready_i(sf_rdy_b),
    .streaming_o(str_b), .underrun_o(und_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    sf_t e;
    #2;
    if (sfv_a && sf_rdy_a) begin
      e.d = data_a; e.p = pre_a; e.l = {1'b0, lane_a};
      qa.push_back(e);
    end
    if (sfv_b && sf_rdy_b) begin
      e.d = data_b; e.p = pre_b; e.l = lane_b;
      qb.push_back(e);
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    bytev = b;
    valid = 1'b1;
    while (!(use_b ? rdy_b : rdy_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vecs++; fails++;
      $display("FAIL push_timeout: byte %h not taken in %0d cycles", b, n);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    valid = 1'b0;
    sf_rdy_a = 1'b1;
    sf_rdy_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({rdy_a, sfv_a, str_a, und_a, data_a, pre_a, lane_a} !== '0) begin
      fails++;
      $display("FAIL reset_a: got %h want 0",
               {rdy_a, sfv_a, str_a, und_a, data_a, pre_a, lane_a});
    end
    vecs++;
    if ({rdy_b, sfv_b, str_b, und_b, data_b, pre_b, lane_b} !== '0) begin
      fails++;
      $display("FAIL reset_b: got %h want 0",
               {rdy_b, sfv_b, str_b, und_b, data_b, pre_b, lane_b});
    end
  endtask

  task automatic test_basic24();
    depth = 2'd1; rate = 3'd1;
    apply_reset();
    push(8'h12); push(8'h34);
    vecs++;
    if (sfv_a !== 1'b0) begin
      fails++; $display("FAIL b24_early_valid: got %b want 0", sfv_a);
    end
    push(8'h56);
    vecs++;
    if (sfv_a !== 1'b1) begin
      fails++; $display("FAIL b24_latency: got %b want 1", sfv_a);
    end
    vecs++;
    if (data_a !== 32'h8123_4560) begin
      fails++; $display("FAIL b24_sf1_data: got %h want 81234560", data_a);
    end
    vecs++;
    if ({pre_a, lane_a, str_a} !== {2'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL b24_sf1_pre_lane_str: got %b want 00_0_1",
               {pre_a, lane_a, str_a});
    end
    push(8'h00); push(8'h00); push(8'h01);
    vecs++;
    if ({sfv_a, data_a} !== {1'b1, 32'h8000_0010}) begin
      fails++;
      $display("FAIL b24_sf2: got %b/%h want 1/80000010", sfv_a, data_a);
    end
    vecs++;
    if (pre_a !== 2'd2) begin
      fails++; $display("FAIL b24_sf2_pre: got %0d want 2", pre_a);
    end
    repeat (7) @(negedge clk);
    vecs++;
    if (str_a !== 1'b0 || qa.size() != 2) begin
      fails++;
      $display("FAIL b24_end: str %b n %0d want 0 2", str_a, qa.size());
    end
  endtask

  task automatic test_frames16();
    logic [191:0] cs;
    logic [191:0] cs_exp;
    logic [15:0]  s;
    logic [1:0]   pe;
    depth = 2'd0; rate = 3'd0;
    apply_reset();
    for (int f = 0; f < 193; f++) begin
      for (int c = 0; c < 2; c++) begin
        s = {8'(f), (c == 1) ? 8'hA5 : 8'h3C};
        push(s[15:8]);
        push(s[7:0]);
      end
    end
    repeat (8) @(negedge clk);
    vecs++;
    if (qa.size() != 386) begin
      fails++; $display("FAIL f16_count: got %0d want 386", qa.size());
    end
    cs = '0;
    for (int i = 0; i < qa.size() && i < 386; i++) begin
      s  = {8'(i / 2), (i % 2 == 1) ? 8'hA5 : 8'h3C};
      pe = (i % 2 == 1) ? 2'd2 : ((i / 2) % 192 == 0) ? 2'd0 : 2'd1;
      vecs++;
      if (qa[i].p !== pe) begin
        fails++;
        $display("FAIL f16_pre[%0d]: got %0d want %0d", i, qa[i].p, pe);
      end
      vecs++;
      if (qa[i].d[29:0] !== {2'b00, s, 12'h000}) begin
        fails++;
        $display("FAIL f16_data[%0d]: got %h want %h", i,
                 qa[i].d[29:0], {2'b00, s, 12'h000});
      end
      vecs++;
      if (^qa[i].d[31:4] !== 1'b0) begin
        fails++; $display("FAIL f16_parity[%0d]: word %h odd", i, qa[i].d);
      end
      if (i % 2 == 1) begin
        vecs++;
        if (qa[i].d[30] !== qa[i-1].d[30]) begin
          fails++;
          $display("FAIL f16_cpair[%0d]: got %b want %b", i,
                   qa[i].d[30], qa[i-1].d[30]);
        end
      end else if (i < 384) begin
        cs[i/2] = qa[i].d[30];
      end
    end
    cs_exp = '0;
    cs_exp[2] = 1'b1;
    cs_exp[33] = 1'b1;
    vecs++;
    if (cs !== cs_exp) begin
      fails++;
      $display("FAIL f16_cs: got %h want %h", cs, cs_exp);
    end
  endtask

  task automatic test_depth32();
    depth = 2'd2; rate = 3'd5;
    apply_reset();
    push(8'hAA); push(8'hBB); push(8'hCC);
    vecs++;
    if (sfv_a !== 1'b0) begin
      fails++; $display("FAIL d32_3bytes_valid: got %b want 0", sfv_a);
    end
    push(8'hDD);
    vecs++;
    if ({sfv_a, data_a, pre_a} !== {1'b1, 32'h0AAB_BCC0, 2'd0}) begin
      fails++;
      $display("FAIL d32_sf1: got %b/%h/%0d want 1/0aabbcc0/0",
               sfv_a, data_a, pre_a);
    end
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    vecs++;
    if ({sfv_a, data_a, pre_a} !== {1'b1, 32'h0112_2330, 2'd2}) begin
      fails++;
      $display("FAIL d32_sf2: got %b/%h/%0d want 1/01122330/2",
               sfv_a, data_a, pre_a);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_lanes();
    logic [31:0] ed[4];
    logic [1:0]  ep[4];
    logic [1:0]  el[4];
    ed = '{32'h0010_2030, 32'h8040_5060, 32'h0070_8090, 32'h80A0_B0C0};
    ep = '{2'd0, 2'd2, 2'd0, 2'd2};
    el = '{2'd0, 2'd0, 2'd1, 2'd1};
    depth = 2'd1; rate = 3'd1;
    apply_reset();
    use_b = 1'b1;
    sf_rdy_b = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if ({sfv_b, rdy_b, data_b} !== {1'b1, 1'b0, 32'h0010_2030}) begin
        fails++;
        $display("FAIL ln_stall[%0d]: got %b/%b/%h want 1/0/00102030",
                 k, sfv_b, rdy_b, data_b);
      end
    end
    sf_rdy_b = 1'b1;
    push(8'h04); push(8'h05); push(8'h06);
    push(8'h07); push(8'h08); push(8'h09);
    push(8'h0A); push(8'h0B); push(8'h0C);
    repeat (8) @(negedge clk);
    use_b = 1'b0;
    vecs++;
    if (qb.size() != 4) begin
      fails++; $display("FAIL ln_count: got %0d want 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      vecs++;
      if ({qb[i].d, qb[i].p, qb[i].l} !== {ed[i], ep[i], el[i]}) begin
        fails++;
        $display("FAIL ln_sf[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i,
                 qb[i].d, qb[i].p, qb[i].l, ed[i], ep[i], el[i]);
      end
    end
  endtask

  task automatic test_stop_resume();
    depth = 2'd1; rate = 3'd1;
    apply_reset();
    repeat (6) push(8'h11);
    repeat (2) @(negedge clk);
    vecs++;
    if (str_a !== 1'b1) begin
      fails++; $display("FAIL st_gap_str: got %b want 1", str_a);
    end
    repeat (12) push(8'h11);
    repeat (4) @(negedge clk);
    vecs++;
    if (str_a !== 1'b1) begin
      fails++; $display("FAIL st_before_expire: got %b want 1", str_a);
    end
    @(negedge clk);
    vecs++;
    if (str_a !== 1'b0) begin
      fails++; $display("FAIL st_expire: got %b want 0", str_a);
    end
    vecs++;
    if (qa.size() != 6) begin
      fails++; $display("FAIL st_count: got %0d want 6", qa.size());
    end else begin
      vecs++;
      if ({qa[0].p, qa[2].p, qa[4].p} !== {2'd0, 2'd1, 2'd1}) begin
        fails++;
        $display("FAIL st_pre: got %0d %0d %0d want 0 1 1",
                 qa[0].p, qa[2].p, qa[4].p);
      end
      vecs++;
      if ({qa[0].d[30], qa[2].d[30], qa[4].d[30]} !== 3'b001) begin
        fails++;
        $display("FAIL st_cbits: got %b want 001",
                 {qa[0].d[30], qa[2].d[30], qa[4].d[30]});
      end
    end
    repeat (3) push(8'h11);
    vecs++;
    if ({sfv_a, pre_a, data_a[30]} !== {1'b1, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL st_restart: got %b/%0d/%b want 1/0/0",
               sfv_a, pre_a, data_a[30]);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_underrun();
    int pulses, pos, svs;
    depth = 2'd1; rate = 3'd1;
    apply_reset();
    push(8'h77);
    pulses = 0; pos = -1; svs = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (und_a) begin pulses++; pos = k; end
      if (sfv_a) svs++;
    end
    vecs++;
    if (pulses != 1 || pos != 4) begin
      fails++;
      $display("FAIL ur_pulse: got %0d pulses at %0d want 1 at 4", pulses, pos);
    end
    vecs++;
    if (svs != 0 || str_a !== 1'b0) begin
      fails++;
      $display("FAIL ur_state: got sv %0d str %b want 0 0", svs, str_a);
    end
    push(8'h12); push(8'h34); push(8'h56);
    vecs++;
    if ({sfv_a, data_a, pre_a} !== {1'b1, 32'h8123_4560, 2'd0}) begin
      fails++;
      $display("FAIL ur_restart: got %b/%h/%0d want 1/81234560/0",
               sfv_a, data_a, pre_a);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset_emit();
    depth = 2'd1; rate = 3'd1;
    apply_reset();
    sf_rdy_a = 1'b0;
    push(8'h9A); push(8'hBC); push(8'hDE);
    vecs++;
    if (sfv_a !== 1'b1) begin
      fails++; $display("FAIL re_emit: got %b want 1", sfv_a);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({rdy_a, sfv_a, str_a, und_a, data_a, pre_a, lane_a} !== '0) begin
      fails++;
      $display("FAIL re_async: got %h want 0",
               {rdy_a, sfv_a, str_a, und_a, data_a, pre_a, lane_a});
    end
    @(negedge clk);
    rst = 1'b0;
    sf_rdy_a = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic24();
    test_frames16();
    test_depth32();
    test_lanes();
    test_stop_resume();
    test_underrun();
    test_reset_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/tx_spdif_framer.md
Name: tx_spdif_framer

Overview:
Parametrised successor to the stereo S/PDIF byte assembler. It consumes a big-endian PCM byte stream through a valid/ready handshake and assembles complete IEC 60958 subframes for NUM_LANES stereo lanes. Each subframe carries correct parity, a 192-frame channel-status block and B/M/W preamble selection. It sits between the output async FIFO read side and the per-lane biphase-mark serialisers.

Parameters:
NUM_LANES, 1, number of stereo S/PDIF lanes; channels per frame = 2*NUM_LANES.
STOP_DELAY, 4, byte clocks of input starvation tolerated before stopping or aborting (1..15).

Ports:
byte_clk_i  in  1  byte clock; all logic on its rising edge
reset_i  in  1  asynchronous, active-high reset
bit_depth_i  in  2  0=16, 1=24, 2=32 (top 24 bits used), 3=invalid (no streaming)
sample_rate_i  in  3  0=44.1k, 1=48k, 2=88.2k, 3=96k, 4=176.4k, 5=192k, 6/7=not indicated
byte_i  in  8  PCM byte, sample MSB byte first
byte_valid_i  in  1  byte_i valid (FIFO not empty)
byte_ready_o  out  1  byte consumed on clock edge with byte_valid_i && byte_ready_o
sf_data_o  out  32  subframe: [3:0]=0, [27:4]=audio (MSB at 27), [28]=V, [29]=U, [30]=C, [31]=P
sf_preamble_o  out  2  0=B, 1=M, 2=W
sf_lane_o  out  $clog2(NUM_LANES)+1  destination lane of the subframe
sf_valid_o  out  1  subframe valid
sf_ready_i  in  1  serialiser accepts the subframe
streaming_o  out  1  high from stream start until return to IDLE
underrun_o  out  1  one-cycle pulse on mid-frame abort

Behaviour:
- Reset: every output 0; FSM=IDLE; ch_idx=0; frame_idx=0; byte_idx=0.
- States: IDLE, FILL, EMIT, STOP.
- IDLE:
  - If byte_valid_i && bit_depth_i!=3, latch depth and rate into internal registers, set streaming_o=1 and go to FILL.
  - bit_depth_i/sample_rate_i changes while streaming are ignored until the next IDLE.
- FILL:
  - byte_ready_o=1.
  - Bytes per sample N = 2/3/4 for depth 0/1/2.
  - Byte k goes to audio bits [27-8k:20-8k] for k<3; byte 3 of a 32-bit sample is discarded.
  - 16-bit samples: audio [11:4]=0.
  - On the N-th accepted byte go to EMIT next cycle, with sf_data_o/preamble/lane registered.
- Subframe fields:
  - V=0, U=0.
  - C = channel-status bit frame_idx, identical for all channels of a frame.
  - P = even parity over [30:4], so that ^sf_data_o[31:4]==0.
- Preamble and lane:
  - ch_idx even: B if frame_idx==0, else M.
  - ch_idx odd: W.
  - sf_lane_o = ch_idx>>1.
- Channel status (bit n of the 192-bit block; all bits not listed are 0):
  - Bit 2 = 1 (copy permitted).
  - Bits 24..27 = fs code, LSB-first: 44.1k=0000, 48k=0100, 88.2k=0001, 96k=0101, 176.4k=0011, 192k=0111, other=1000.
  - 16-bit depth: bit 32=0, bits 33..35 = 1,0,0.
  - 24/32-bit depth: bit 32=1, bits 33..35 = 1,0,1.
- EMIT:
  - sf_valid_o=1; sf_data_o stable until sf_valid_o && sf_ready_i.
  - On accept: ch_idx++. At wrap (2*NUM_LANES), ch_idx=0 and frame_idx = (frame_idx==191) ? 0 : frame_idx+1.
  - Then go to FILL, except: at frame boundary (ch_idx now 0) with byte_valid_i=0, go to STOP loaded with STOP_DELAY.
  - Latency: last byte accepted -> sf_valid_o high = 1 cycle.
- STOP:
  - Counter decrements each cycle; byte_ready_o=0.
  - byte_valid_i high before the counter expires: back to FILL, indices preserved (resume, no gap in frame numbering).
  - Counter expires: IDLE, streaming_o=0, frame_idx=0.
- Mid-frame starvation (FILL with byte_idx!=0 or ch_idx!=0) counts consecutive cycles without a byte.
  - Reaching STOP_DELAY: underrun_o pulses 1 cycle; partial frame discarded; go to IDLE; streaming_o=0; indices cleared.
  - Any accepted byte clears the count.
- Reset mid-operation: immediate return to reset values; sf_valid_o drops asynchronously.

Test Plan:
- NUM_LANES=1, 24-bit, 48k; feed 12 34 56 | 00 00 01, sf_ready_i=1 -> subframe 1: audio=0x123456, P=1, preamble B, lane 0. Subframe 2: audio=0x000001, P=1, preamble W. sf_valid_o 1 cycle after each last byte.
- Stream 193 stereo frames, 16-bit, 44.1k -> B at frames 0 and 192, M elsewhere. Recovered C bits: bit2=1, bits24..27=0000, bit32=0, bits33..35=100.
- 32-bit depth, bytes AA BB CC DD -> audio=0xAABBCC; DD discarded; 4 bytes consumed per subframe.
- NUM_LANES=2: hold sf_ready_i=0 for 5 cycles -> sf_data_o stable, byte_ready_o=0; emission order lanes 0,0,1,1 with preambles B,W,B,W in frame 0.
- STOP_DELAY=4: empty at frame boundary, data returns after 2 cycles -> resume, frame_idx continues. Empty for 4 cycles -> streaming_o=0, next start uses B.
- Starve after 1 byte mid-frame for 4 cycles -> underrun_o single pulse, streaming_o=0, no sf_valid_o for the partial sample. Assert reset_i during EMIT -> all outputs 0 immediately.
